// File: rtl/activity_led_pkg.sv
// Shared definitions for the activity LED: drive modes, blink FSM encoding
// and the gap length multiplier between blink-code repetitions.
package activity_led_pkg;

    localparam logic [1:0] LED_OFF     = 2'b00;
    localparam logic [1:0] LED_DIRECT  = 2'b01;
    localparam logic [1:0] LED_STRETCH = 2'b10;
    localparam logic [1:0] LED_CODE    = 2'b11;

    localparam int unsigned GAP_MULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10,
        ST_GAP  = 2'b11
    } blink_state_e;

endpackage

// File: rtl/activity_stretcher.sv
// One-channel retriggerable pulse stretcher: any activity reloads the full
// count, and busy stays high until the counter has drained to zero.
module activity_stretcher #(
    parameter int unsigned STRETCH_CYCLES = 2097152
) (
    input  logic clk,
    input  logic rst,
    input  logic act,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_d;
    logic             busy_q;

    // Next count: reload on activity, otherwise drain without wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (act) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = '0;
        end
        busy_d = (cnt_d != '0);
    end

    // Counter and registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/activity_led.sv
// Activity indicator: per-channel stretchers feed a mode mux (off, raw,
// stretched, blink-code) whose result is PWM-gated into a registered LED.
module activity_led
    import activity_led_pkg::*;
#(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned STRETCH_CYCLES = 2097152,
    parameter int unsigned BLINK_CYCLES   = 4194304,
    parameter int unsigned PWM_W          = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] act,
    input  logic [1:0]          mode,
    input  logic [PWM_W-1:0]    brightness,
    output logic [CHANNELS-1:0] busy,
    output logic                led
);

    localparam int unsigned TMR_W = $clog2(GAP_MULT * BLINK_CYCLES + 1);
    localparam int unsigned FL_W  = $clog2(CHANNELS + 1);
    localparam logic [TMR_W-1:0] PHASE_LOAD = TMR_W'(BLINK_CYCLES);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_MULT * BLINK_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [FL_W-1:0]  FL_ONE     = FL_W'(1);

    // Flash count for the lowest active channel (index + 1)
    function automatic logic [FL_W-1:0] first_flashes(input logic [CHANNELS-1:0] v);
        first_flashes = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (v[i]) begin
                first_flashes = FL_W'(i + 1);
            end
        end
    endfunction

    logic [CHANNELS-1:0] busy_s;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        activity_stretcher #(
            .STRETCH_CYCLES(STRETCH_CYCLES)
        ) u_stretcher (
            .clk (clk),
            .rst (rst),
            .act (act[i]),
            .busy(busy_s[i])
        );
    end

    logic [1:0]       mode_d,       mode_q;
    logic [PWM_W-1:0] brightness_d, brightness_q;
    logic [PWM_W-1:0] pwm_cnt_d,    pwm_cnt_q;
    logic             led_d,        led_q;
    blink_state_e     state_d,      state_q;
    logic [TMR_W-1:0] timer_d,      timer_q;
    logic [FL_W-1:0]  flashes_d,    flashes_q;
    logic             blink_d,      blink_q;
    logic             gate_s;
    logic             src_s;
    logic             tmr_done_s;

    assign tmr_done_s = (timer_q <= TMR_ONE);

    // PWM gate and mode mux; mode and brightness pass through a register first
    always_comb begin
        mode_d       = mode;
        brightness_d = brightness;
        pwm_cnt_d    = pwm_cnt_q + PWM_W'(1);
        gate_s       = (pwm_cnt_q < brightness_q) | (&brightness_q);
        case (mode_q)
            LED_OFF:     src_s = 1'b0;
            LED_DIRECT:  src_s = |act;
            LED_STRETCH: src_s = |busy_s;
            LED_CODE:    src_s = blink_q;
            default:     src_s = 1'b0;
        endcase
        led_d = src_s & gate_s;
    end

    // Blink-code sequencer; leaving code mode discards any sequence in flight
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        flashes_d = flashes_q;
        blink_d   = blink_q;
        if (mode != LED_CODE) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            flashes_d = '0;
            blink_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|busy_s) begin
                        state_d   = ST_ON;
                        flashes_d = first_flashes(busy_s);
                        timer_d   = PHASE_LOAD;
                        blink_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ON: begin
                    if (tmr_done_s) begin
                        state_d   = ST_OFF;
                        flashes_d = flashes_q - FL_ONE;
                        timer_d   = PHASE_LOAD;
                        blink_d   = 1'b0;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                ST_OFF: begin
                    if (tmr_done_s && (flashes_q != '0)) begin
                        state_d = ST_ON;
                        timer_d = PHASE_LOAD;
                        blink_d = 1'b1;
                    end else if (tmr_done_s) begin
                        state_d = ST_GAP;
                        timer_d = GAP_LOAD;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                ST_GAP: begin
                    if (tmr_done_s) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    timer_d   = '0;
                    flashes_d = '0;
                    blink_d   = 1'b0;
                end
            endcase
        end
    end

    // All top-level state
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= LED_OFF;
            brightness_q <= '0;
            pwm_cnt_q    <= '0;
            led_q        <= 1'b0;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            flashes_q    <= '0;
            blink_q      <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            brightness_q <= brightness_d;
            pwm_cnt_q    <= pwm_cnt_d;
            led_q        <= led_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            flashes_q    <= flashes_d;
            blink_q      <= blink_d;
        end
    end

    assign busy = busy_s;
    assign led  = led_q;

endmodule

// File: tb/tb_activity_led.sv
// Directed bench for activity_led: expected busy/led values are queued as
// stimulus is planned and checked one entry per clock after each edge.
module tb_activity_led;
    import activity_led_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] act;
    logic [1:0] mode;
    logic [1:0] brightness;
    logic [2:0] busy;
    logic       led;

    int compared   = 0;
    int mismatched = 0;
    logic [1:0] pwm_ref = 2'd0;

    typedef struct packed {
        logic [2:0] busy;
        logic       chk_busy;
        logic       led;
        logic       chk_led;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    activity_led #(
        .CHANNELS      (3),
        .STRETCH_CYCLES(8),
        .BLINK_CYCLES  (4),
        .PWM_W         (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .act       (act),
        .mode      (mode),
        .brightness(brightness),
        .busy      (busy),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [2:0] b, input logic cb,
                        input logic l, input logic cl);
        exp_t e;
        e.busy = b; e.chk_busy = cb; e.led = l; e.chk_led = cl;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic push_led(input string tag, input logic l, input int n);
        for (int i = 0; i < n; i++) push(tag, 3'b000, 1'b0, l, 1'b1);
    endtask

    // One clock: track the PWM phase, then check the oldest expectation
    task automatic tick();
        exp_t  e;
        string t;
        @(posedge clk);
        if (rst) pwm_ref = 2'd0;
        else     pwm_ref = pwm_ref + 2'd1;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e.chk_busy) begin
                compared++;
                assert (busy === e.busy) else begin
                    mismatched++;
                    $error("FAIL %s: busy=%b expected %b", t, busy, e.busy);
                end
            end
            if (e.chk_led) begin
                compared++;
                assert (led === e.led) else begin
                    mismatched++;
                    $error("FAIL %s: led=%b expected %b", t, led, e.led);
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1; act = 3'b111; mode = LED_STRETCH; brightness = 2'd3;

        // Reset holds busy/led low despite activity; busy rises once released
        for (int i = 0; i < 3; i++) push("reset", 3'b000, 1'b1, 1'b0, 1'b1);
        run(3);
        rst = 1'b0;
        push("reset_release", 3'b111, 1'b1, 1'b0, 1'b0);
        tick();
        act = 3'b000;
        run(12);

        // Single pulse stretched to 8 clocks
        push("stretch", 3'b001, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) push("stretch", 3'b001, 1'b1, 1'b1, 1'b1);
        push("stretch_end", 3'b000, 1'b1, 1'b1, 1'b1);
        push("stretch_end", 3'b000, 1'b1, 1'b0, 1'b1);
        act = 3'b001; tick();
        act = 3'b000; run(9);

        // Retrigger at k+5 extends busy through edge k+12
        push("retrig", 3'b001, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) push("retrig", 3'b001, 1'b1, 1'b1, 1'b1);
        push("retrig_end", 3'b000, 1'b1, 1'b1, 1'b1);
        push("retrig_end", 3'b000, 1'b1, 1'b0, 1'b1);
        act = 3'b001; tick();
        act = 3'b000; run(4);
        act = 3'b001; tick();
        act = 3'b000; run(9);

        // PWM brightness in direct mode
        mode = LED_DIRECT; act = 3'b010; brightness = 2'd1;
        run(2);
        for (int i = 0; i < 12; i++) begin
            push("pwm_b1", 3'b000, 1'b0, (pwm_ref < 2'd1), 1'b1);
            tick();
        end
        brightness = 2'd0; run(2);
        push_led("pwm_b0", 1'b0, 8); run(8);
        brightness = 2'd3; run(2);
        push_led("pwm_b3", 1'b1, 8); run(8);

        act = 3'b000; mode = LED_OFF; run(12);
        mode = LED_CODE; run(2);

        // Blink code for channel 1: two flashes, then a long gap and idle
        push_led("blink", 1'b0, 2);
        push_led("blink_on1", 1'b1, 4);
        push_led("blink_off1", 1'b0, 4);
        push_led("blink_on2", 1'b1, 4);
        push_led("blink_gap", 1'b0, 30);
        act = 3'b010; tick();
        act = 3'b000; run(43);
        compared++;
        assert (dut.state_q === ST_IDLE) else begin
            mismatched++;
            $error("FAIL blink_idle: state=%0d expected %0d", dut.state_q, ST_IDLE);
        end

        // Priority: channel 1 wins; switching to channel 2 finishes the 2-flash code first
        push_led("prio", 1'b0, 2);
        push_led("prio_a_on", 1'b1, 4); push_led("prio_a_off", 1'b0, 4);
        push_led("prio_a_on", 1'b1, 4); push_led("prio_a_gap", 1'b0, 21);
        push_led("prio_b_on", 1'b1, 4); push_led("prio_b_off", 1'b0, 4);
        push_led("prio_b_on", 1'b1, 4); push_led("prio_b_gap", 1'b0, 21);
        push_led("prio_c_on", 1'b1, 4); push_led("prio_c_off", 1'b0, 4);
        push_led("prio_c_on", 1'b1, 4); push_led("prio_c_off", 1'b0, 4);
        push_led("prio_c_on", 1'b1, 4);
        act = 3'b110; run(36);
        act = 3'b100; run(52);

        act = 3'b000; mode = LED_OFF; run(12);

        // Abort in the second ON phase, then restart from the first flash
        push_led("abort", 1'b0, 2);
        push_led("abort_on1", 1'b1, 4); push_led("abort_off1", 1'b0, 4);
        push_led("abort_on2", 1'b1, 2); push_led("abort_dark", 1'b0, 2);
        push_led("fresh_on1", 1'b1, 4); push_led("fresh_off1", 1'b0, 4);
        push_led("fresh_on2", 1'b1, 4); push_led("fresh_gap", 1'b0, 21);
        mode = LED_CODE; act = 3'b010; run(11);
        mode = LED_OFF; run(2);
        mode = LED_CODE; run(34);

        // Reset in the middle of an ON phase
        rst = 1'b1;
        push("rst_mid", 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        compared++;
        assert (dut.state_q === ST_IDLE) else begin
            mismatched++;
            $error("FAIL rst_mid_state: state=%0d expected %0d", dut.state_q, ST_IDLE);
        end
        rst = 1'b0; act = 3'b000;

        compared++;
        assert (exp_q.size() == 0) else begin
            mismatched++;
            $error("FAIL sb_drain: left=%0d expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
